// File: rtl/spi_pkt_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_pkt_ctrl: decodes SPI packets {type, len_hi, len_lo, payload} into   |
// | FIFO writes, config register writes or discards; returns space/status.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module spi_pkt_ctrl #(
  parameter int         SPACE_W   = 12,
  parameter int         NUM_REGS  = 4,
  parameter int         ADDR_W    = 2,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         spi_rx_data_i,
  input  logic               spi_rx_stb_i,
  input  logic               spi_tsx_start_i,
  output logic [7:0]         spi_tx_data_o,
  input  logic [SPACE_W-1:0] fifo_space_free_i,
  input  logic               fifo_full_i,
  output logic [7:0]         fifo_data_o,
  output logic               fifo_wr_o,
  output logic [ADDR_W-1:0]  reg_addr_o,
  output logic [7:0]         reg_data_o,
  output logic               reg_wr_o,
  output logic [7:0]         status_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_TYPE, S_LEN_HI, S_LEN_LO, S_GET_SPACE,
    S_REG_A, S_REG_D, S_FIFO, S_STATUS, S_DISCARD
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          type_q, type_d;
  logic [7:0]          len_hi_q, len_hi_d;
  logic [15:0]         rem_q, rem_d;
  logic [15:0]         snap_q, snap_d;
  logic                first_q, first_d;
  logic [7:0]          addr_q, addr_d;
  logic [7:0]          tx_q, tx_d;
  logic [7:0]          fdata_q, fdata_d;
  logic                fwr_q, fwr_d;
  logic [ADDR_W-1:0]   raddr_q, raddr_d;
  logic [7:0]          rdata_q, rdata_d;
  logic                rwr_q, rwr_d;
  logic                ovf_q, ovf_d;
  logic                bad_addr_q, bad_addr_d;
  logic                bad_type_q, bad_type_d;

  logic [15:0] w_space16;
  logic [15:0] w_len;
  logic        w_addr_ok;
  logic [7:0]  w_status;

  assign w_space16 = 16'(fifo_space_free_i);
  assign w_len     = {len_hi_q, spi_rx_data_i};
  // Full byte compared so addresses beyond the register window are caught
  assign w_addr_ok = ({1'b0, addr_q} < 9'(NUM_REGS));
  assign w_status  = {ovf_q, bad_addr_q, bad_type_q, 5'b0};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      type_q     <= '0;
      len_hi_q   <= '0;
      rem_q      <= '0;
      snap_q     <= '0;
      first_q    <= 1'b0;
      addr_q     <= '0;
      tx_q       <= '0;
      fdata_q    <= '0;
      fwr_q      <= 1'b0;
      raddr_q    <= '0;
      rdata_q    <= '0;
      rwr_q      <= 1'b0;
      ovf_q      <= 1'b0;
      bad_addr_q <= 1'b0;
      bad_type_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      type_q     <= type_d;
      len_hi_q   <= len_hi_d;
      rem_q      <= rem_d;
      snap_q     <= snap_d;
      first_q    <= first_d;
      addr_q     <= addr_d;
      tx_q       <= tx_d;
      fdata_q    <= fdata_d;
      fwr_q      <= fwr_d;
      raddr_q    <= raddr_d;
      rdata_q    <= rdata_d;
      rwr_q      <= rwr_d;
      ovf_q      <= ovf_d;
      bad_addr_q <= bad_addr_d;
      bad_type_q <= bad_type_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    type_d     = type_q;
    len_hi_d   = len_hi_q;
    rem_d      = rem_q;
    snap_d     = snap_q;
    first_d    = first_q;
    addr_d     = addr_q;
    tx_d       = tx_q;
    fdata_d    = fdata_q;
    fwr_d      = 1'b0;
    raddr_d    = raddr_q;
    rdata_d    = rdata_q;
    rwr_d      = 1'b0;
    ovf_d      = ovf_q;
    bad_addr_d = bad_addr_q;
    bad_type_d = bad_type_q;

    // A new transaction aborts everything, including a coincident strobe
    if (spi_tsx_start_i) begin
      state_d = S_TYPE;
      tx_d    = SYNC_BYTE;
    end else if (spi_rx_stb_i) begin
      case (state_q)
        S_IDLE: ;
        S_TYPE: begin
          type_d  = spi_rx_data_i;
          state_d = S_LEN_HI;
        end
        S_LEN_HI: begin
          len_hi_d = spi_rx_data_i;
          state_d  = S_LEN_LO;
        end
        S_LEN_LO: begin
          rem_d   = w_len;
          first_d = 1'b1;
          if (w_len == 16'd0) begin
            state_d = S_IDLE;
          end else begin
            case (type_q)
              8'd0: begin
                snap_d  = w_space16;
                tx_d    = w_space16[15:8];
                state_d = S_GET_SPACE;
              end
              8'd1: state_d = S_REG_A;
              8'd2: state_d = S_FIFO;
              8'd3: begin
                tx_d       = w_status;
                ovf_d      = 1'b0;
                bad_addr_d = 1'b0;
                bad_type_d = 1'b0;
                state_d    = S_STATUS;
              end
              default: begin
                bad_type_d = 1'b1;
                state_d    = S_DISCARD;
              end
            endcase
          end
        end
        default: begin
          case (state_q)
            S_GET_SPACE: begin
              tx_d    = first_q ? snap_q[7:0] : 8'h00;
              first_d = 1'b0;
            end
            S_REG_A: begin
              addr_d  = spi_rx_data_i;
              state_d = S_REG_D;
            end
            S_REG_D: begin
              if (w_addr_ok) begin
                rdata_d = spi_rx_data_i;
                raddr_d = addr_q[ADDR_W-1:0];
                rwr_d   = 1'b1;
              end else begin
                bad_addr_d = 1'b1;
              end
              state_d = S_REG_A;
            end
            S_FIFO: begin
              tx_d = w_space16[7:0];
              if (!fifo_full_i) begin
                fdata_d = spi_rx_data_i;
                fwr_d   = 1'b1;
              end else begin
                ovf_d = 1'b1;
              end
            end
            default: tx_d = 8'h00;
          endcase
          if (rem_q != 16'd0) rem_d = rem_q - 16'd1;
          if (rem_q == 16'd1) state_d = S_IDLE;
        end
      endcase
    end
  end

  assign spi_tx_data_o = tx_q;
  assign fifo_data_o   = fdata_q;
  assign fifo_wr_o     = fwr_q;
  assign reg_addr_o    = raddr_q;
  assign reg_data_o    = rdata_q;
  assign reg_wr_o      = rwr_q;
  assign status_o      = w_status;

endmodule
`default_nettype wire

// File: tb/tb_spi_pkt_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_spi_pkt_ctrl: directed scenario bench for spi_pkt_ctrl.               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_spi_pkt_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_stb = 1'b0;
  logic        tsx = 1'b0;
  logic [7:0]  tx;
  logic [11:0] space = 12'h123;
  logic        full = 1'b0;
  logic [7:0]  fdata;
  logic        fwr;
  logic [1:0]  raddr;
  logic [7:0]  rdata;
  logic        rwr;
  logic [7:0]  status;

  int total = 0;
  int bad = 0;
  int n_fwr = 0;
  int n_rwr = 0;

  logic [7:0] c_tx, c_fdata, c_rdata, c_status;
  logic       c_fwr, c_rwr;
  logic [1:0] c_raddr;

  spi_pkt_ctrl #(.SPACE_W(12), .NUM_REGS(4), .ADDR_W(2), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst),
    .spi_rx_data_i(rx_data), .spi_rx_stb_i(rx_stb), .spi_tsx_start_i(tsx),
    .spi_tx_data_o(tx),
    .fifo_space_free_i(space), .fifo_full_i(full),
    .fifo_data_o(fdata), .fifo_wr_o(fwr),
    .reg_addr_o(raddr), .reg_data_o(rdata), .reg_wr_o(rwr),
    .status_o(status)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (fwr) n_fwr++;
    if (rwr) n_rwr++;
  end

  task automatic capture();
    c_tx = tx; c_fdata = fdata; c_fwr = fwr;
    c_rdata = rdata; c_raddr = raddr; c_rwr = rwr; c_status = status;
  endtask

  // One byte strobe followed by two idle cycles; outputs captured the cycle after
  task automatic send(input logic [7:0] b);
    @(negedge clk); rx_data = b; rx_stb = 1'b1;
    @(negedge clk); rx_stb = 1'b0; capture();
    @(negedge clk);
  endtask

  task automatic start();
    @(negedge clk); tsx = 1'b1;
    @(negedge clk); tsx = 1'b0; capture();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if ({tx, fdata, rdata, status} !== 32'h0) begin bad++;
      $display("FAIL reset_bytes got tx=%h fd=%h rd=%h st=%h want 0", tx, fdata, rdata, status); end
    total++; if ({fwr, rwr, raddr} !== 4'h0) begin bad++;
      $display("FAIL reset_ctrl got fwr=%b rwr=%b ra=%h want 0", fwr, rwr, raddr); end
    rst = 1'b0;
  endtask

  task automatic test_fifo_basic();
    logic [7:0] bytes [3];
    int n0;
    bytes = '{8'h11, 8'h22, 8'h33};
    space = 12'h123;
    start();
    total++; if (c_tx !== 8'hA5) begin bad++; $display("FAIL t1_sync got %h want a5", c_tx); end
    n0 = n_fwr;
    send(8'h02); send(8'h00); send(8'h03);
    for (int i = 0; i < 3; i++) begin
      send(bytes[i]);
      total++; if (c_fwr !== 1'b1 || c_fdata !== bytes[i] || c_tx !== 8'h23) begin bad++;
        $display("FAIL t1_write%0d got wr=%b d=%h tx=%h want 1 %h 23", i, c_fwr, c_fdata, c_tx, bytes[i]); end
    end
    send(8'h44);
    total++; if (n_fwr - n0 !== 3) begin bad++; $display("FAIL t1_count got %0d want 3", n_fwr - n0); end
  endtask

  task automatic test_fifo_full();
    int n0;
    n0 = n_fwr;
    start();
    send(8'h02); send(8'h00); send(8'h04);
    send(8'hAA); send(8'hBB);
    full = 1'b1; send(8'hCC);
    total++; if (c_fwr !== 1'b0) begin bad++; $display("FAIL t2_drop got wr=%b want 0", c_fwr); end
    full = 1'b0; send(8'hDD);
    total++; if (c_fwr !== 1'b1 || c_fdata !== 8'hDD) begin bad++;
      $display("FAIL t2_after got wr=%b d=%h want 1 dd", c_fwr, c_fdata); end
    total++; if (n_fwr - n0 !== 3) begin bad++; $display("FAIL t2_count got %0d want 3", n_fwr - n0); end
    total++; if (status !== 8'h80) begin bad++; $display("FAIL t2_ovf got %h want 80", status); end
    start();
    send(8'h03); send(8'h00); send(8'h01);
    total++; if (c_tx !== 8'h80 || c_status !== 8'h00) begin bad++;
      $display("FAIL t2_status got tx=%h st=%h want 80 00", c_tx, c_status); end
    send(8'h5A);
    total++; if (c_tx !== 8'h00) begin bad++; $display("FAIL t2_status_pl got %h want 00", c_tx); end
  endtask

  task automatic test_set_reg();
    int n0;
    n0 = n_rwr;
    start();
    send(8'h01); send(8'h00); send(8'h05);
    send(8'h02);
    total++; if (c_rwr !== 1'b0) begin bad++; $display("FAIL t3_addr_nowr got %b want 0", c_rwr); end
    send(8'h7F);
    total++; if (c_rwr !== 1'b1 || c_raddr !== 2'd2 || c_rdata !== 8'h7F) begin bad++;
      $display("FAIL t3_write got wr=%b a=%h d=%h want 1 2 7f", c_rwr, c_raddr, c_rdata); end
    send(8'h09); send(8'h55);
    total++; if (c_rwr !== 1'b0 || c_raddr !== 2'd2 || c_rdata !== 8'h7F || c_status !== 8'h40) begin bad++;
      $display("FAIL t3_badaddr got wr=%b a=%h d=%h st=%h want 0 2 7f 40", c_rwr, c_raddr, c_rdata, c_status); end
    send(8'h03);
    total++; if (n_rwr - n0 !== 1) begin bad++; $display("FAIL t3_count got %0d want 1", n_rwr - n0); end
    start();
    send(8'h03); send(8'h00); send(8'h01);
    total++; if (c_tx !== 8'h40) begin bad++; $display("FAIL t3_status got %h want 40", c_tx); end
    send(8'h00);
  endtask

  task automatic test_get_space();
    logic [7:0] exp [4];
    exp = '{8'h0A, 8'hBC, 8'h00, 8'h00};
    space = 12'hABC;
    start();
    send(8'h00); send(8'h00); send(8'h03);
    total++; if (c_tx !== exp[0]) begin bad++; $display("FAIL t4_hi got %h want %h", c_tx, exp[0]); end
    space = 12'h111;
    for (int i = 1; i < 4; i++) begin
      send(8'hEE);
      total++; if (c_tx !== exp[i]) begin bad++; $display("FAIL t4_byte%0d got %h want %h", i, c_tx, exp[i]); end
    end
    space = 12'h123;
  endtask

  task automatic test_discard();
    int n0;
    start();
    send(8'h07); send(8'h00); send(8'h02);
    send(8'h12); send(8'h34);
    total++; if (c_tx !== 8'h00 || status !== 8'h20) begin bad++;
      $display("FAIL t5_discard got tx=%h st=%h want 00 20", c_tx, status); end
    n0 = n_fwr;
    start();
    send(8'h02); send(8'h00); send(8'h00);
    send(8'h99);
    total++; if (n_fwr - n0 !== 0) begin bad++; $display("FAIL t5_len0 got %0d writes want 0", n_fwr - n0); end
    start();
    send(8'h03); send(8'h00); send(8'h01);
    total++; if (c_tx !== 8'h20) begin bad++; $display("FAIL t5_status got %h want 20", c_tx); end
    send(8'h00);
  endtask

  task automatic test_abort();
    int n0;
    start();
    send(8'h02); send(8'h00); send(8'h03);
    send(8'h11);
    n0 = n_fwr;
    @(negedge clk); rx_data = 8'h22; rx_stb = 1'b1; tsx = 1'b1;
    @(negedge clk); rx_stb = 1'b0; tsx = 1'b0; capture();
    total++; if (c_fwr !== 1'b0 || c_tx !== 8'hA5 || n_fwr - n0 !== 0) begin bad++;
      $display("FAIL t6_tsx got wr=%b tx=%h n=%0d want 0 a5 0", c_fwr, c_tx, n_fwr - n0); end
    @(negedge clk);
    send(8'h02); send(8'h00); send(8'h01); send(8'h77);
    total++; if (c_fwr !== 1'b1 || c_fdata !== 8'h77) begin bad++;
      $display("FAIL t6_restart got wr=%b d=%h want 1 77", c_fwr, c_fdata); end
    full = 1'b1;
    start();
    send(8'h02); send(8'h00); send(8'h05); send(8'h01);
    full = 1'b0;
    @(negedge clk); rx_data = 8'h02; rx_stb = 1'b1; rst = 1'b1;
    @(negedge clk); rx_stb = 1'b0; capture();
    total++; if ({c_tx, c_fdata, c_rdata, c_status, c_fwr, c_rwr, c_raddr} !== 36'h0) begin bad++;
      $display("FAIL t6_rst got tx=%h fd=%h rd=%h st=%h fwr=%b rwr=%b want 0", c_tx, c_fdata, c_rdata, c_status, c_fwr, c_rwr); end
    rst = 1'b0;
    n0 = n_fwr;
    send(8'h55);
    total++; if (n_fwr - n0 !== 0) begin bad++; $display("FAIL t6_idle got %0d writes want 0", n_fwr - n0); end
  endtask

  initial begin
    test_reset();
    test_fifo_basic();
    test_fifo_full();
    test_set_reg();
    test_get_space();
    test_discard();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
